// File: rtl/core_bus_pkg.sv
// Shared definitions for the core register bus initiator: FSM state encoding,
// default widths and the data word returned with error responses.
package core_bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned LEN_WIDTH      = 4;
  localparam int unsigned TIMER_WIDTH    = 8;

  localparam logic [DATA_WIDTH-1:0] RSP_ERR_DATA = 32'h0;
  localparam logic [DATA_WIDTH-1:0] WR_ACK_DATA  = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RSP    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/core_bus_timeout.sv
// Loadable down-counter used as the bus ready timeout.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : reload count with load_value (held while not waiting on the bus)
//   load_value  : cycles-minus-one allowed before expiry
//   expired_c   : count has reached zero (combinational from the count register)
module core_bus_timeout
  import core_bus_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired_c
);

  logic [WIDTH-1:0] count;

  // Counts down while not loading and saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/core_bus_master.sv
// Core register bus initiator: turns a command stream into single/burst
// register accesses and reports read data, write completion or timeout on a
// response stream.
//   cmd_*      : command stream (we, first address, beats-1)
//   wdata_*    : write word stream, one word per write beat
//   rsp_*      : response stream (data, last, err)
//   cs/we/address/write_data/read_data/ready : core register bus
module core_bus_master
  import core_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  cs,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ready
);

  state_t               state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] beat;
  logic                 last_beat;
  logic                 expired_c;

  assign last_beat = (beat == len);

  // Timer is held at TIMEOUT-1 outside ACCESS, so it reads zero on the
  // TIMEOUT-th cycle of an access.
  core_bus_timeout #(
    .WIDTH (TIMER_WIDTH)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load       (state != ST_ACCESS),
    .load_value (TIMER_WIDTH'(TIMEOUT - 1)),
    .expired_c  (expired_c)
  );

  // Command sequencer; every output is a register updated on the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      cs          <= 1'b0;
      we          <= 1'b0;
      address     <= '0;
      write_data  <= '0;
      len         <= '0;
      beat        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            we        <= cmd_we;
            address   <= cmd_addr;
            len       <= cmd_len;
            beat      <= '0;
            if (cmd_we) begin
              wdata_ready <= 1'b1;
              state       <= ST_WDATA;
            end else begin
              cs    <= 1'b1;
              state <= ST_ACCESS;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_WDATA: begin
          if (wdata_valid && wdata_ready) begin
            wdata_ready <= 1'b0;
            write_data  <= wdata;
            cs          <= 1'b1;
            state       <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (ready) begin
            cs <= 1'b0;
            if (!we) begin
              rsp_data  <= read_data;
              rsp_err   <= 1'b0;
              rsp_last  <= last_beat;
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end else if (last_beat) begin
              rsp_data  <= WR_ACK_DATA;
              rsp_err   <= 1'b0;
              rsp_last  <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end else begin
              beat        <= beat + LEN_WIDTH'(1);
              address     <= address + ADDR_WIDTH'(1);
              wdata_ready <= 1'b1;
              state       <= ST_WDATA;
            end
          end else if (expired_c) begin
            // Dead responder: end the command with a single error response.
            cs       <= 1'b0;
            rsp_data <= RSP_ERR_DATA;
            rsp_err  <= 1'b1;
            rsp_last <= 1'b1;
            if (we && !last_beat) begin
              wdata_ready <= 1'b1;
              state       <= ST_DRAIN;
            end else begin
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end
          end
        end

        ST_RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              we        <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              beat    <= beat + LEN_WIDTH'(1);
              address <= address + ADDR_WIDTH'(1);
              cs      <= 1'b1;
              state   <= ST_ACCESS;
            end
          end
        end

        ST_DRAIN: begin
          // Discard the words of the aborted beats so the write stream stays
          // aligned with the next command.
          if (wdata_valid && wdata_ready) begin
            beat <= beat + LEN_WIDTH'(1);
            if ((beat + LEN_WIDTH'(1)) == len) begin
              wdata_ready <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= ST_RSP;
            end
          end
        end

        default: begin
          cs    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_master.sv
// Testbench for core_bus_master: a tk1-like register file responder with
// combinational ready, a table of command vectors with hand-computed
// responses, and hand-written latency and reset-during-access sequences.
module tb_core_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic        cs, we;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;
  logic        ready;

  logic        stall_en;
  logic [7:0]  stall_addr;
  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_bus_master #(
    .ADDR_WIDTH (8),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .cs          (cs),
    .we          (we),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready)
  );

  // Responder: zero-wait, optionally dead at one address.
  assign ready     = cs && !(stall_en && (address == stall_addr));
  assign read_data = mem[address];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem[0] <= 32'h746B3120;
      mem[1] <= 32'h6d6b6466;
      mem[2] <= 32'h00000004;
    end else if (cs && we && ready) begin
      mem[address] <= write_data;
    end
  end

  typedef struct {
    logic             we;
    logic [7:0]       addr;
    logic [3:0]       len;
    logic [3:0][31:0] wd;
    int               rsp_stall;
    logic             sen;
    logic [7:0]       saddr;
    int               exp_n;
    logic [3:0][31:0] exp_data;
    logic             exp_err;
    int               exp_cs;
    int               exp_pulses;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [3:0] l,
                              input logic [3:0][31:0] wd, input int rs, input logic se,
                              input logic [7:0] sa, input int n, input logic [3:0][31:0] ed,
                              input logic err, input int ecs, input int ep);
    vec_t v;
    v.we = w; v.addr = a; v.len = l; v.wd = wd; v.rsp_stall = rs; v.sen = se;
    v.saddr = sa; v.exp_n = n; v.exp_data = ed; v.exp_err = err; v.exp_cs = ecs;
    v.exp_pulses = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Runs one command from a negedge; checks every response plus cs activity.
  task automatic run_cmd(input vec_t v, input string tag);
    int nrsp = 0, nw = 0, cs_cyc = 0, pulses = 0, wait_r = 0, cyc = 0, post = 0;
    bit done = 0, prev_cs = 0, hs_c, hs_w, hs_r;
    stall_en = v.sen; stall_addr = v.saddr;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_len = v.len;
    wdata_valid = v.we; wdata = v.wd[0]; rsp_ready = 1'b0;
    while (post < 12 && cyc < 400) begin
      if (cs) begin
        cs_cyc++;
        if (!prev_cs) pulses++;
      end
      prev_cs = cs;
      hs_c = cmd_valid && cmd_ready;
      hs_w = wdata_valid && wdata_ready;
      hs_r = rsp_valid && rsp_ready;
      if (hs_r) begin
        if (nrsp < 4) begin
          check({tag, "_data"}, rsp_data, v.exp_data[2'(nrsp)]);
          check({tag, "_last"}, 32'(rsp_last), 32'(nrsp == v.exp_n - 1));
          check({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err && (nrsp == v.exp_n - 1)));
        end
        nrsp++;
        if (rsp_last) done = 1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) post++;
      if (hs_c) cmd_valid = 1'b0;
      if (hs_w) nw++;
      wdata_valid = v.we && (nw <= int'(v.len));
      wdata = (nw < 4) ? v.wd[2'(nw)] : 32'h0;
      if (rsp_valid) begin
        wait_r++;
        rsp_ready = (wait_r > v.rsp_stall);
      end else begin
        wait_r = 0;
        rsp_ready = 1'b0;
      end
    end
    cmd_valid = 1'b0; wdata_valid = 1'b0; rsp_ready = 1'b0; stall_en = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_nrsp"}, 32'(nrsp), 32'(v.exp_n));
    check({tag, "_cs_cycles"}, 32'(cs_cyc), 32'(v.exp_cs));
    check({tag, "_cs_pulses"}, 32'(pulses), 32'(v.exp_pulses));
    check({tag, "_words"}, 32'(nw), v.we ? 32'(v.len) + 32'd1 : 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0; stall_en = 1'b0; stall_addr = '0;

    vecs[0] = mk(0, 8'h00, 0, '0, 0, 0, 0, 1, {96'h0, 32'h746B3120}, 0, 1, 1);
    vecs[1] = mk(0, 8'h00, 2, '0, 0, 0, 0, 3,
                 {32'h0, 32'h00000004, 32'h6d6b6466, 32'h746B3120}, 0, 3, 3);
    vecs[2] = mk(0, 8'h00, 2, '0, 5, 0, 0, 3,
                 {32'h0, 32'h00000004, 32'h6d6b6466, 32'h746B3120}, 0, 3, 3);
    vecs[3] = mk(1, 8'h09, 0, {96'h0, 32'h5}, 0, 0, 0, 1, '0, 0, 1, 1);
    vecs[4] = mk(0, 8'h09, 0, '0, 0, 0, 0, 1, {96'h0, 32'h5}, 0, 1, 1);
    vecs[5] = mk(1, 8'hff, 1, {64'h0, 32'hBBBB0002, 32'hAAAA0001}, 0, 0, 0, 1, '0, 0, 2, 2);
    vecs[6] = mk(0, 8'hff, 1, '0, 0, 0, 0, 2, {64'h0, 32'hBBBB0002, 32'hAAAA0001}, 0, 2, 2);
    vecs[7] = mk(0, 8'h20, 3, '0, 0, 1, 8'h20, 1, '0, 1, 8, 1);
    vecs[8] = mk(1, 8'h10, 3, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 1, 8'h11, 1, '0, 1, 9, 2);
    vecs[9] = mk(0, 8'h10, 1, '0, 0, 0, 0, 2, {64'h0, 32'hC0DE0011, 32'h00000001}, 0, 2, 2);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Single read minimum latency
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h01; cmd_len = 4'd0;
    check("lat_c0_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("lat_c1_cs", 32'(cs), 32'd1);
    check("lat_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_c2_cs", 32'(cs), 32'd0);
    check("lat_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lat_c2_data", rsp_data, 32'h6d6b6466);
    check("lat_c2_last", 32'(rsp_last), 32'd1);
    @(negedge clk);
    check("lat_c3_rsp_valid", 32'(rsp_valid), 32'd0);
    check("lat_c3_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b0;

    // Reset while cs is high
    stall_en = 1'b1; stall_addr = 8'h20;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h20; cmd_len = 4'd0; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst_pre_cs", 32'(cs), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs", 32'(cs), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0; stall_en = 1'b0;
    @(negedge clk);
    check("midrst_after_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd(mk(0, 8'h02, 0, '0, 0, 0, 0, 1, {96'h0, 32'h00000004}, 0, 1, 1), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
